// File: rtl/inst_stream_decoder_if.sv
// inst_stream_decoder_if: instruction-in and decoded-out handshakes of the stream decoder
//   inst_in/inst_valid_in/inst_ready_out : 32-bit instruction word stream
//   dec_out/dec_valid_out/dec_ready_in   : decoded entry stream (iType,lIndex,sIndex,sType,prop,prop2,data,data2)
//   busy_out, err_count_out              : status
//   slave = decoder side, master = producer/consumer side
interface inst_stream_decoder_if #(
    parameter int LIGHT_INDEX_SIZE = 6,
    parameter int SHAPE_INDEX_SIZE = 19,
    parameter int ERR_W = 8
);
    localparam int DW = 3 + LIGHT_INDEX_SIZE + SHAPE_INDEX_SIZE + 5 + 5 + 5 + 16 + 16;
    logic [31:0] inst_in;
    logic inst_valid_in;
    logic inst_ready_out;
    logic [DW-1:0] dec_out;
    logic dec_valid_out;
    logic dec_ready_in;
    logic busy_out;
    logic [ERR_W-1:0] err_count_out;
    modport slave (
        input inst_in, inst_valid_in, dec_ready_in,
        output inst_ready_out, dec_out, dec_valid_out, busy_out, err_count_out
    );
    modport master (
        output inst_in, inst_valid_in, dec_ready_in,
        input inst_ready_out, dec_out, dec_valid_out, busy_out, err_count_out
    );
endinterface

// File: rtl/inst_stream_decoder.sv
// inst_stream_decoder: decodes C/L/SI/SE/F instruction words into a FWFT buffer of decoded entries
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (slave)    : instruction stream in, decoded stream out, busy and illegal-opcode count
module inst_stream_decoder #(
    parameter int DEPTH = 4,
    parameter int LIGHT_INDEX_SIZE = 6,
    parameter int SHAPE_INDEX_SIZE = 19,
    parameter int ERR_W = 8
) (
    input logic clk_in,
    input logic rst_in,
    inst_stream_decoder_if.slave bus
);
    localparam int L = LIGHT_INDEX_SIZE;
    localparam int S = SHAPE_INDEX_SIZE;
    localparam int DW = 3 + L + S + 5 + 5 + 5 + 16 + 16;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [2:0] OP_RENDER = 3'd0, OP_FRAME = 3'd1, OP_CAMERA_SET = 3'd2, OP_LIGHT_SET = 3'd3,
                           OP_SHAPE_INIT = 3'd4, OP_SHAPE_SET = 3'd5, OP_UNSUPPORTED = 3'd6;

    typedef enum logic {WORD0, WORD1} state_t;

    state_t state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count;
    logic [ERR_W-1:0] errCount;
    logic [S-1:0] seIndex;
    logic [4:0] seProp, seProp2;
    logic [2:0] opc, iType;
    logic [L-1:0] lIndex;
    logic [S-1:0] sIndex;
    logic [4:0] sType, prop, prop2;
    logic [15:0] data, data2;
    logic accept, isSe0, illegal, push, pop;

    assign opc = bus.inst_in[2:0];
    assign accept = bus.inst_valid_in && bus.inst_ready_out;
    assign isSe0 = state == WORD0 && opc == 3'b101;
    assign illegal = state == WORD0 && (opc == 3'b010 || opc == 3'b110 || opc == 3'b111);
    // SE word0 only latches its fields; the entry is pushed with the payload word
    assign push = accept && !isSe0;
    assign pop = bus.dec_valid_out && bus.dec_ready_in;

    always_comb begin
        iType = OP_UNSUPPORTED;
        lIndex = '0;
        sIndex = '0;
        sType = '0;
        prop = '0;
        prop2 = '0;
        data = '0;
        data2 = '0;
        if (state == WORD1) begin
            iType = OP_SHAPE_SET;
            sIndex = seIndex;
            prop = seProp;
            prop2 = seProp2;
            data = bus.inst_in[15:0];
            data2 = bus.inst_in[31:16];
        end else begin
            case (opc)
                3'b000: iType = bus.inst_in[3] ? OP_FRAME : OP_RENDER;
                3'b001: begin
                    iType = OP_CAMERA_SET;
                    prop = bus.inst_in[7:3];
                    data = bus.inst_in[31:16];
                end
                3'b011: begin
                    iType = OP_LIGHT_SET;
                    lIndex = bus.inst_in[3+:L];
                    prop = bus.inst_in[3+L+:5];
                    data = bus.inst_in[31:16];
                end
                3'b100: begin
                    iType = OP_SHAPE_INIT;
                    sIndex = bus.inst_in[3+:S];
                    sType = bus.inst_in[3+S+:5];
                end
                default: iType = OP_UNSUPPORTED;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= WORD0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            errCount <= '0;
            seIndex <= '0;
            seProp <= '0;
            seProp2 <= '0;
        end else begin
            if (accept) state <= isSe0 ? WORD1 : WORD0;
            if (accept && isSe0) begin
                seIndex <= bus.inst_in[3+:S];
                seProp <= bus.inst_in[3+S+:5];
                seProp2 <= bus.inst_in[27+:5];
            end
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            if (accept && illegal && !(&errCount)) errCount <= errCount + 1'b1;
        end
    end

    // storage needs no reset: dec_out is forced to zero while the buffer is empty
    always_ff @(posedge clk_in) begin
        if (push) mem[wrPtr] <= {iType, lIndex, sIndex, sType, prop, prop2, data, data2};
    end

    assign bus.inst_ready_out = count != FULL;
    assign bus.dec_valid_out = count != '0;
    assign bus.dec_out = (count != '0) ? mem[rdPtr] : '0;
    assign bus.busy_out = state == WORD1 || count != '0;
    assign bus.err_count_out = errCount;
endmodule

// File: tb/tb_inst_stream_decoder.sv
// tb_inst_stream_decoder: directed and random stimulus against a queue-based reference model
module tb_inst_stream_decoder;
    localparam int DEPTH = 4;
    localparam int L = 6;
    localparam int S = 19;
    localparam int ERR_W = 8;
    localparam int DW = 3 + L + S + 5 + 5 + 5 + 16 + 16;
    localparam int OP_RENDER = 0, OP_FRAME = 1, OP_CAMERA_SET = 2, OP_LIGHT_SET = 3,
                   OP_SHAPE_INIT = 4, OP_SHAPE_SET = 5, OP_UNSUPPORTED = 6;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int failures = 0;
    int popped = 0;
    int errModel = 0;
    logic pend = 0;
    logic [31:0] pendWord = 0;
    logic [DW-1:0] expQ [$];

    inst_stream_decoder_if #(.LIGHT_INDEX_SIZE(L), .SHAPE_INDEX_SIZE(S), .ERR_W(ERR_W)) bus ();

    inst_stream_decoder #(.DEPTH(DEPTH), .LIGHT_INDEX_SIZE(L), .SHAPE_INDEX_SIZE(S), .ERR_W(ERR_W)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [31:0] it, input logic [31:0] li, input logic [31:0] si,
                                        input logic [31:0] st, input logic [31:0] p, input logic [31:0] p2,
                                        input logic [31:0] d, input logic [31:0] d2);
        return {3'(it), L'(li), S'(si), 5'(st), 5'(p), 5'(p2), 16'(d), 16'(d2)};
    endfunction

    function automatic logic [DW-1:0] refEntry(input logic [31:0] w, input logic payload, input logic [31:0] w0);
        if (payload)
            return mk(OP_SHAPE_SET, 0, (w0 >> 3) % (1 << S), 0, (w0 >> (3 + S)) % 32, w0 >> 27, w % 65536, w >> 16);
        case (w % 8)
            0: return mk(((w >> 3) % 2 == 1) ? OP_FRAME : OP_RENDER, 0, 0, 0, 0, 0, 0, 0);
            1: return mk(OP_CAMERA_SET, 0, 0, 0, (w >> 3) % 32, 0, w >> 16, 0);
            3: return mk(OP_LIGHT_SET, (w >> 3) % (1 << L), 0, 0, (w >> (3 + L)) % 32, 0, w >> 16, 0);
            4: return mk(OP_SHAPE_INIT, 0, (w >> 3) % (1 << S), (w >> (3 + S)) % 32, 0, 0, 0, 0);
            default: return mk(OP_UNSUPPORTED, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelAccept(input logic [31:0] w);
        if (pend) begin
            expQ.push_back(refEntry(w, 1, pendWord));
            pend = 0;
        end else if (w % 8 == 5) begin
            pend = 1;
            pendWord = w;
        end else begin
            expQ.push_back(refEntry(w, 0, 0));
            if (w % 8 == 2 || w % 8 == 6 || w % 8 == 7) errModel = (errModel < ERR_MAX) ? errModel + 1 : ERR_MAX;
        end
    endtask

    // one clock: drive at posedge+1, check and update the model at negedge
    task automatic cycle(input logic [31:0] w, input logic v, input logic r, output logic acc);
        logic mReady;
        bus.inst_in = w;
        bus.inst_valid_in = v;
        bus.dec_ready_in = r;
        @(negedge clk);
        mReady = expQ.size() < DEPTH;
        chk("inst_ready", DW'(bus.inst_ready_out), DW'(mReady));
        chk("dec_valid", DW'(bus.dec_valid_out), DW'(expQ.size() != 0));
        chk("busy", DW'(bus.busy_out), DW'(pend || expQ.size() != 0));
        chk("err_count", DW'(bus.err_count_out), DW'(errModel));
        if (expQ.size() != 0) begin
            chk("dec_out", bus.dec_out, expQ[0]);
            if (r) begin
                void'(expQ.pop_front());
                popped++;
            end
        end
        acc = v && mReady;
        if (acc) modelAccept(w);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic r);
        logic acc;
        acc = 0;
        for (int i = 0; i < 40 && !acc; i++) cycle(w, 1, r, acc);
        chk("send_accepted", DW'(acc), DW'(1));
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        for (int i = 0; i < n; i++) cycle(32'h0, 0, r, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && expQ.size() != 0; i++) cycle(32'h0, 0, 1, acc);
        chk("drain_empty", DW'(expQ.size()), DW'(0));
    endtask

    task automatic resetDut();
        rst = 1;
        bus.inst_valid_in = 0;
        bus.dec_ready_in = 0;
        @(posedge clk);
        #1;
        rst = 0;
        expQ.delete();
        pend = 0;
        errModel = 0;
        chk("rst_dec_valid", DW'(bus.dec_valid_out), DW'(0));
        chk("rst_dec_out", bus.dec_out, DW'(0));
        chk("rst_busy", DW'(bus.busy_out), DW'(0));
        chk("rst_err", DW'(bus.err_count_out), DW'(0));
        chk("rst_ready", DW'(bus.inst_ready_out), DW'(1));
    endtask

    initial begin
        int p0;
        logic acc;
        bus.inst_in = 0;
        bus.inst_valid_in = 0;
        bus.dec_ready_in = 0;
        repeat (2) @(posedge clk);
        resetDut();

        send(32'h3C00_0009, 0);
        chk("c_type", bus.dec_out, mk(OP_CAMERA_SET, 0, 0, 0, 1, 0, 32'h3C00, 0));
        chk("c_valid", DW'(bus.dec_valid_out), DW'(1));
        drain();

        send(32'h1234_0E2B, 0);
        chk("l_type", bus.dec_out, mk(OP_LIGHT_SET, 5, 0, 0, 7, 0, 32'h1234, 0));
        drain();

        send(32'h0140_0084, 0);
        chk("si_type", bus.dec_out, mk(OP_SHAPE_INIT, 0, 32'h10, 5, 0, 0, 0, 0));
        drain();

        send(32'h41C0_0015, 0);
        chk("se_word0_no_entry", DW'(bus.dec_valid_out), DW'(0));
        chk("se_word0_busy", DW'(bus.busy_out), DW'(1));
        idle(3, 0);
        send(32'h4000_3C00, 0);
        chk("se_type", bus.dec_out, mk(OP_SHAPE_SET, 0, 2, 0, 7, 8, 32'h3C00, 32'h4000));
        drain();

        p0 = popped;
        repeat (4) send(32'h8, 0);
        chk("full_ready_low", DW'(bus.inst_ready_out), DW'(0));
        send(32'h8, 1);
        drain();
        chk("full_pop_count", DW'(popped - p0), DW'(5));

        send(32'h2, 1);
        send(32'h6, 1);
        send(32'h7, 1);
        chk("err_three", DW'(bus.err_count_out), DW'(3));
        drain();
        for (int i = 0; i < (1 << ERR_W) + 2; i++) send({29'($urandom), 3'b110 | 3'($urandom_range(0, 1))}, 1);
        drain();
        chk("err_saturated", DW'(bus.err_count_out), DW'(8'hFF));

        resetDut();
        for (int i = 0; i < 400; i++)
            cycle($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
        if (pend) send($urandom, 1);
        drain();

        resetDut();
        send(32'h0, 0);
        send(32'h8, 0);
        send(32'h41C0_0015, 0);
        chk("pre_rst_busy", DW'(bus.busy_out), DW'(1));
        resetDut();
        send(32'h0, 0);
        chk("post_rst_render", bus.dec_out, mk(OP_RENDER, 0, 0, 0, 0, 0, 0, 0));
        chk("post_rst_valid", DW'(bus.dec_valid_out), DW'(1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_stream_decoder.md
Name: inst_stream_decoder

Overview:
Streaming instruction decoder for the render processor front end. It accepts 32-bit instruction words over a valid/ready handshake and decodes C/L/SI/SE/F-type words, including two-word SE instructions that carry paired property writes. It queues decoded instructions in a parametrised first-word-fall-through (FWFT) buffer and emits them to the scene-state/render controller over a second valid/ready handshake. It replaces ad-hoc single-cycle decode: index widths and buffer depth are parametrised, paired-property SE writes are added, and illegal opcodes are counted.

Parameters:
DEPTH, 4, decoded-instruction buffer entries (power of 2, >=2)
LIGHT_INDEX_SIZE, 6, light index width
SHAPE_INDEX_SIZE, 19, shape index width (3+SHAPE_INDEX_SIZE+10 <= 32)
ERR_W, 8, illegal-opcode counter width

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
inst_in  in  32  instruction word
inst_valid_in  in  1  word valid
inst_ready_out  out  1  word accepted when valid&ready
dec_out  out  DW  decoded instruction, DW=3+LIGHT_INDEX_SIZE+SHAPE_INDEX_SIZE+5+5+5+16+16 (75 at defaults); field order MSB->LSB: iType, lIndex, sIndex, sType, prop, prop2, data, data2
dec_valid_out  out  1  dec_out valid
dec_ready_in  in  1  consumer pops when valid&ready
busy_out  out  1  high while in WORD1 state or buffer non-empty
err_count_out  out  ERR_W  illegal opcodes seen, saturating

Behaviour:
- Encoding; fields pack upward from bit 3. opcode=[2:0].
- F (000): [3]=1 -> opFrame, 0 -> opRender.
- C (001): prop=[7:3], data=[31:16] -> opCameraSet.
- L (011): lIndex=[3+:L], prop=[3+L+:5], data=[31:16] -> opLightSet.
- SI (100): sIndex=[3+:S], sType=[3+S+:5] -> opShapeInit.
- SE (101): two words. Word0: sIndex=[3+:S], prop=[3+S+:5], prop2=[27+:5]. Word1: data=[15:0], data2=[31:16]. Result -> opShapeSet. prop2==0 means single write; data2 is still captured.
- Other opcodes -> opUnsupported entry. err_count increments and holds at all-ones.
- All fields not defined for a type are zero in the entry.
- FSM:
  - WORD0 (reset state): accepted SE word0 -> WORD1 (latch sIndex/prop/prop2). Any other accepted word pushes one entry.
  - WORD1: the next accepted word is the SE payload regardless of its bits. It pushes the entry and returns to WORD0.
- Handshakes:
  - inst_ready_out = (count<DEPTH). It also gates SE word0, which pushes nothing.
  - Push when the accepted word completes an instruction.
  - Pop on dec_valid_out&dec_ready_in.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Full: ready low, pop still allowed; ready returns the cycle after a pop.
- Latency: entry appears on dec_out/dec_valid_out the cycle after its final word is accepted (registered). Throughput is 1 entry/cycle.
- dec_out is stable while valid and not ready.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Reset (any cycle, including mid-SE or full):
  - FSM=WORD0, buffer emptied, partial SE discarded.
  - dec_valid_out=0, dec_out=0, busy_out=0, err_count_out=0.
  - inst_ready_out=1 from the first cycle after reset deasserts.

Test Plan:
- C-type 0x3C00_0009 -> next cycle dec_valid=1; iType=opCameraSet, prop=1, data=0x3C00, all other fields 0.
- L-type 0x1234_0E2B -> iType=opLightSet, lIndex=5, prop=7, data=0x1234.
- SI 0x0140_0084 -> opShapeInit, sIndex=0x10, sType=5. Then SE 0x41C0_0015 followed by 0x4000_3C00 with a 3-cycle valid gap between them -> no output after word0; busy=1; after word1, one entry: sIndex=2, prop=7, prop2=8, data=0x3C00, data2=0x4000.
- dec_ready=0, push 5 F-type words (0x8 repeated) -> 4 entries held, ready=0 after the 4th. Assert dec_ready with a word presented -> pop and push in the same cycle; all 5 opFrame entries emerge in order; none dropped or duplicated.
- Opcodes 010, 110, 111 -> three opUnsupported entries, err_count=3. Force 2^ERR_W+2 illegal opcodes -> err_count saturates at 0xFF.
- Reset asserted after SE word0 with buffer holding 2 entries -> dec_valid=0, busy=0, err=0. Next word 0x0000_0000 decodes as a standalone opRender, not as SE payload.
